// File: rtl/patch_sweep_ctrl.sv
// patch_sweep_ctrl
//
// Exhaustive sweep controller for checking a patch netlist against a reference
// function. After an accepted start it walks vec through 0 .. 2^NUM_IN-1, holds
// each vector for SETTLE cycles (WAIT), then compares patch_out against
// golden_out for one cycle (CMP). Mismatches are counted and the lowest failing
// vector is captured. A one-cycle done pulse ends the sweep, with pass valid
// alongside it; results then hold until the next accepted start.
//
// Parameters
//   NUM_IN : number of patch inputs swept (1..8)
//   SETTLE : cycles a vector is held before its compare (1..15)
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle sweep request, honoured only in IDLE
//   abort        : cancels a running sweep (WAIT/CMP only)
//   patch_out    : response of the patch netlist
//   golden_out   : response of the reference function for the same vector
//   vec          : stimulus vector
//   busy         : sweep in progress
//   done         : one-cycle completion pulse
//   pass         : last completed sweep had no mismatches
//   mismatch_cnt : mismatching vectors in current/last sweep
//   first_fail   : lowest mismatching vector (valid when fail_valid=1)
//   fail_valid   : at least one mismatch recorded
//
// Build option
//   SWEEP_STOP_ON_FAIL_EN : when defined, the first mismatch ends the sweep
//                           immediately; otherwise every vector is compared.

module patch_sweep_ctrl #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              patch_out,
  input  logic              golden_out,
  output logic [NUM_IN-1:0] vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   mismatch_cnt,
  output logic [NUM_IN-1:0] first_fail,
  output logic              fail_valid
);

  localparam int unsigned       CntW       = 4;
  localparam logic [CntW-1:0]   SettleInit = CntW'(SETTLE);
  localparam logic [NUM_IN-1:0] VecLast    = '1;
  // 2^NUM_IN: the largest possible count, used as a saturation guard
  localparam logic [NUM_IN:0]   MisMax     = {1'b1, {NUM_IN{1'b0}}};

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCmp,
    StDone
  } state_e;

  state_e            r_state,  w_state_nxt;
  logic [NUM_IN-1:0] r_vec,    w_vec_nxt;
  logic [CntW-1:0]   r_cnt,    w_cnt_nxt;
  logic [NUM_IN:0]   r_mis,    w_mis_nxt;
  logic [NUM_IN-1:0] r_ff,     w_ff_nxt;
  logic              r_fv,     w_fv_nxt;
  logic              r_pass,   w_pass_nxt;

  logic w_miscmp;
  logic w_stop;

  assign w_miscmp = patch_out ^ golden_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_mis   <= '0;
      r_ff    <= '0;
      r_fv    <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vec   <= w_vec_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mis   <= w_mis_nxt;
      r_ff    <= w_ff_nxt;
      r_fv    <= w_fv_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_vec_nxt   = r_vec;
    w_cnt_nxt   = r_cnt;
    w_mis_nxt   = r_mis;
    w_ff_nxt    = r_ff;
    w_fv_nxt    = r_fv;
    w_pass_nxt  = r_pass;
    w_stop      = 1'b0;

    unique case (r_state)
      StIdle: begin
        // start beats a simultaneous abort simply because abort is not looked at here
        if (start) begin
          w_vec_nxt   = '0;
          w_cnt_nxt   = SettleInit;
          w_mis_nxt   = '0;
          w_ff_nxt    = '0;
          w_fv_nxt    = 1'b0;
          w_pass_nxt  = 1'b0;
          w_state_nxt = StWait;
        end
      end

      StWait: begin
        if (abort) begin
          w_vec_nxt   = '0;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
          // counter hits zero on this edge: the vector has settled for SETTLE cycles
          if (r_cnt == CntW'(1)) begin
            w_state_nxt = StCmp;
          end
        end
      end

      StCmp: begin
        if (abort) begin
          // this cycle's compare is dropped; pass stays cleared from start
          w_vec_nxt   = '0;
          w_state_nxt = StIdle;
        end else begin
          if (w_miscmp) begin
            if (r_mis != MisMax) begin
              w_mis_nxt = r_mis + 1'b1;
            end
            if (!r_fv) begin
              w_ff_nxt = r_vec;
              w_fv_nxt = 1'b1;
            end
`ifdef SWEEP_STOP_ON_FAIL_EN
            w_stop = 1'b1;
`else
            w_stop = 1'b0;
`endif
          end

          if ((r_vec == VecLast) || w_stop) begin
            // pass registered on entry to DONE so it is valid alongside done
            w_pass_nxt  = !w_miscmp && (r_mis == '0);
            w_state_nxt = StDone;
          end else begin
            w_vec_nxt   = r_vec + 1'b1;
            w_cnt_nxt   = SettleInit;
            w_state_nxt = StWait;
          end
        end
      end

      StDone: begin
        w_vec_nxt   = '0;
        w_state_nxt = StIdle;
      end

      default: begin
        w_vec_nxt   = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign vec          = r_vec;
  assign busy         = (r_state == StWait) || (r_state == StCmp);
  assign done         = (r_state == StDone);
  assign pass         = r_pass;
  assign mismatch_cnt = r_mis;
  assign first_fail   = r_ff;
  assign fail_valid   = r_fv;

endmodule

// File: tb/tb_patch_sweep_ctrl.sv
// Directed bench for patch_sweep_ctrl: default instance (NUM_IN=4, SETTLE=1)
// plus a SETTLE=3 instance for the slower-settle timing.

module tb_patch_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, start3, abort, patch, mode;
  logic       golden;
  logic [3:0] vec, vec3, ff, ff3;
  logic [4:0] cnt, cnt3;
  logic       busy, done, pass, fv;
  logic       busy3, done3, pass3, fv3;

  // mode=1: reference function n36 | (n29 & ~n31 & ~n33); mode=0: tied to patch
  assign golden = mode ? (vec[3] | (vec[0] & ~vec[1] & ~vec[2])) : patch;

  patch_sweep_ctrl #(.NUM_IN(4), .SETTLE(1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .patch_out    (patch),
    .golden_out   (golden),
    .vec          (vec),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .mismatch_cnt (cnt),
    .first_fail   (ff),
    .fail_valid   (fv)
  );

  patch_sweep_ctrl #(.NUM_IN(4), .SETTLE(3)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start3),
    .abort        (abort),
    .patch_out    (patch),
    .golden_out   (patch),
    .vec          (vec3),
    .busy         (busy3),
    .done         (done3),
    .pass         (pass3),
    .mismatch_cnt (cnt3),
    .first_fail   (ff3),
    .fail_valid   (fv3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the edge index (counted from the start-sampling edge) at which done
  // is first seen, or -1 if it never appears within limit edges.
  task automatic wait_done(input bit sel3, input int base, input int limit, output int edges);
    edges = -1;
    for (int k = base + 1; k <= limit; k++) begin
      tick();
      if ((sel3 ? done3 : done) === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int n;
  int pulses;

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    abort  = 1'b0;
    patch  = 1'b0;
    mode   = 1'b0;

    // Reset state
    #3;
    check_eq("rst_vec", vec, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_pass", pass, 0);
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_fv", fv, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Golden tied to patch: clean sweep
    do_start();
    check_eq("t1_busy", busy, 1);
    check_eq("t1_vec0", vec, 0);
    tick(); tick(); tick();
    check_eq("t1_vec_e3", vec, 1);
    wait_done(0, 3, 60, n);
    check_eq("t1_done_edge", n, 32);
    check_eq("t1_pass", pass, 1);
    check_eq("t1_cnt", cnt, 0);
    check_eq("t1_fv", fv, 0);
    tick();
    check_eq("t1_done_1cyc", done, 0);
    check_eq("t1_pass_hold", pass, 1);
    check_eq("t1_vec_idle", vec, 0);

    // Reference function vs stuck-at-0 patch
    mode = 1'b1;
    do_start();
    wait_done(0, 0, 60, n);
`ifdef SWEEP_STOP_ON_FAIL_EN
    check_eq("t2_done_edge", n, 4);
    check_eq("t2_cnt", cnt, 1);
`else
    check_eq("t2_done_edge", n, 32);
    check_eq("t2_cnt", cnt, 9);
`endif
    check_eq("t2_ff", ff, 1);
    check_eq("t2_fv", fv, 1);
    check_eq("t2_pass", pass, 0);
    tick();
    check_eq("t2_cnt_hold", cnt === 5'd0, 0);

    // start+abort together in IDLE, then repeated start mid-sweep
    mode  = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_eq("t3_start_wins", busy, 1);
    check_eq("t3_cnt_clr", cnt, 0);
    check_eq("t3_fv_clr", fv, 0);
    for (int i = 0; i < 10; i++) tick();
    check_eq("t3_vec5", vec, 5);
    do_start();
    wait_done(0, 11, 60, n);
    check_eq("t3_done_edge", n, 32);
    check_eq("t3_pass", pass, 1);
    tick();

    // Abort at vec=7
    do_start();
    for (int i = 0; i < 14; i++) tick();
    check_eq("t4_vec7", vec, 7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("t4_busy", busy, 0);
    check_eq("t4_vec", vec, 0);
    check_eq("t4_done", done, 0);
    check_eq("t4_pass", pass, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check_eq("t4_no_done", pulses, 0);

    // Asynchronous reset at vec=10
    mode = 1'b1;
    do_start();
    for (int i = 0; i < 20; i++) tick();
`ifndef SWEEP_STOP_ON_FAIL_EN
    check_eq("t5_vec10", vec, 10);
    check_eq("t5_cnt_pre", cnt, 3);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_vec", vec, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_cnt", cnt, 0);
    check_eq("t5_ff", ff, 0);
    check_eq("t5_fv", fv, 0);
    check_eq("t5_pass", pass, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    check_eq("t5_no_done", pulses, 0);

    // SETTLE=3 instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    tick(); tick(); tick();
    check_eq("t6_vec_e3", vec3, 0);
    tick();
    check_eq("t6_vec_e4", vec3, 1);
    wait_done(1, 4, 90, n);
    check_eq("t6_done_edge", n, 64);
    check_eq("t6_pass", pass3, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/patch_sweep_ctrl.md
PATCH_SWEEP_CTRL -- requirements
Module: patch_sweep_ctrl

Interface
REQ-001 Parameter NUM_IN, default 4; number of patch inputs swept, range 1..8.
REQ-002 Parameter SETTLE, default 1; cycles a vector is held before compare, range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-006 abort  input  1  cancels a running sweep.
REQ-007 patch_out  input  1  response of the patch netlist under test.
REQ-008 golden_out  input  1  response of the reference (spec) function for the same vector.
REQ-009 vec  output  NUM_IN  stimulus to the patch inputs; bit0=n29, bit1=n31, bit2=n33, bit3=n36 when NUM_IN=4.
REQ-010 busy  output  1  high from the cycle after start is accepted until done or abort.
REQ-011 done  output  1  one-cycle pulse at sweep completion.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 mismatch_cnt  output  NUM_IN+1  mismatching vectors in current/last sweep.
REQ-014 first_fail  output  NUM_IN  lowest vec value that mismatched; valid only when fail_valid=1.
REQ-015 fail_valid  output  1  at least one mismatch recorded in current/last sweep.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, CMP, DONE; encoding free.
REQ-017 IDLE: start=1 SHALL load vec=0, settle counter=SETTLE, clear mismatch_cnt, fail_valid, first_fail, pass, and enter WAIT.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 WAIT: counter decrements each cycle; on the edge where it reaches zero the FSM SHALL enter CMP; vec SHALL stay constant throughout WAIT and CMP.
REQ-020 CMP: if patch_out!=golden_out, mismatch_cnt SHALL increment and, if fail_valid=0, first_fail=vec and fail_valid=1, all on the same edge.
REQ-021 CMP with vec=2^NUM_IN-1 SHALL enter DONE; otherwise vec SHALL increment by 1, counter reload SETTLE, enter WAIT.
REQ-022 Each vector SHALL occupy exactly SETTLE+1 cycles; done SHALL be high in the cycle following the 2^NUM_IN*(SETTLE+1)th edge after the edge that samples start.
REQ-023 DONE: done=1 and pass=(mismatch_cnt==0) for one cycle, then IDLE; pass, mismatch_cnt, first_fail, fail_valid SHALL hold until the next accepted start.
REQ-024 abort=1 in WAIT or CMP SHALL return to IDLE on the next edge, discard that cycle's compare, leave pass=0, and never pulse done; abort in IDLE/DONE SHALL have no effect.
REQ-025 abort and start together in IDLE: start SHALL win.
REQ-026 mismatch_cnt SHALL not wrap (max 2^NUM_IN fits NUM_IN+1 bits).
REQ-027 vec SHALL return to 0 on entry to IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, fail_valid=0, independent of clk.
REQ-029 Reset asserted mid-sweep SHALL discard the sweep; no done pulse after release.

Configuration
REQ-030 Macro SWEEP_STOP_ON_FAIL_EN defined: the first mismatch in CMP SHALL enter DONE directly (mismatch_cnt=1, pass=0); undefined: the sweep SHALL always run all 2^NUM_IN vectors.

Verification
REQ-031 NUM_IN=4, SETTLE=1, golden_out tied to patch_out -> done 32 edges after start, pass=1, mismatch_cnt=0, fail_valid=0.
REQ-032 golden_out = n36 | (n29 & ~n31 & ~n33) from vec, patch_out=0 -> mismatch_cnt=9, first_fail=4'h1, fail_valid=1, pass=0.
REQ-033 Same as REQ-032 with SWEEP_STOP_ON_FAIL_EN -> done 4 edges after start, mismatch_cnt=1, first_fail=4'h1.
REQ-034 start repulsed at vec=5 during sweep -> ignored, sweep completes at edge 32 unchanged; abort at vec=7 -> IDLE next edge, busy=0, no done, vec=0.
REQ-035 rst_n low at vec=10 asynchronously -> all outputs zero before next edge; after release, no done until a new start.
REQ-036 SETTLE=3, golden=patch -> vec changes every 4 cycles, done 64 edges after start.
